xnor_compare_pipe: RTL and testbench



---
 rtl/xnor_pkg.sv | 17 +
 rtl/xnor_pipe_stage.sv | 37 +++
 rtl/xnor_compare_pipe.sv | 94 +++++++++
 tb/tb_xnor_compare_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/xnor_pkg.sv
// Shared constants for the bubbled XNOR compare pipe: mask offsets
// and occupancy-state encoding.
package xnor_pkg;

    localparam int A_OFS = 0;

    function automatic int b_ofs(input int width);
        return width;
    endfunction

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HALF  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/xnor_pipe_stage.sv
// Generic valid/ready pipeline register with async active-low reset.
// Loads whenever the slot is free or being drained this cycle.
module xnor_pipe_stage
    import xnor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid;
    logic [W-1:0] data;

    assign in_ready  = !valid || out_ready;
    assign out_valid = valid;
    assign out_data  = data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (in_valid && in_ready) begin
            valid <= 1'b1;
            data  <= in_data;
        end else if (out_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xnor_compare_pipe.sv
// Two-stage bubbled XNOR word comparator with valid/ready stream.
// Define XNOR_MATCH_COUNT_EN to enable the saturating match counter.
module xnor_compare_pipe
    import xnor_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [2*WIDTH-1:0] BubblesMask = '0,
    parameter int               CNT_WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     input1,
    input  logic [WIDTH-1:0]     input2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 equal,
    input  logic                 count_clear,
    output logic [CNT_WIDTH-1:0] match_count
);

    localparam int B_OFS = b_ofs(WIDTH);

    logic [WIDTH-1:0]   real_a;
    logic [WIDTH-1:0]   real_b;
    logic [2*WIDTH-1:0] s1_data;
    logic               s1_v;
    logic               s2_accept;
    logic [WIDTH-1:0]   xnor_w;
    logic               s2_v;
    logic [WIDTH:0]     s2_data;

    assign real_a = input1 ^ BubblesMask[A_OFS +: WIDTH];
    assign real_b = input2 ^ BubblesMask[B_OFS +: WIDTH];

    xnor_pipe_stage #(.W(2 * WIDTH)) u_s1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({real_b, real_a}),
        .out_valid (s1_v),
        .out_ready (s2_accept),
        .out_data  (s1_data)
    );

    assign xnor_w = ~(s1_data[WIDTH-1:0] ^ s1_data[2*WIDTH-1:WIDTH]);

    xnor_pipe_stage #(.W(WIDTH + 1)) u_s2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (s1_v),
        .in_ready  (s2_accept),
        .in_data   ({&xnor_w, xnor_w}),
        .out_valid (s2_v),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign out_valid = s2_v;
    assign result    = s2_data[WIDTH-1:0];
    assign equal     = s2_data[WIDTH];

`ifdef XNOR_MATCH_COUNT_EN
    logic                 hit;
    logic [CNT_WIDTH-1:0] cnt;

    assign hit = s2_v && out_ready && equal;

    // A counted handshake wins over clear, so clear+hit yields 1.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (hit) begin
            if (count_clear)
                cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            else if (!(&cnt))
                cnt <= cnt + 1'b1;
        end else if (count_clear) begin
            cnt <= '0;
        end
    end

    assign match_count = cnt;
`else
    logic unused_clear;

    assign unused_clear = count_clear;
    assign match_count  = '0;
`endif

endmodule

// File: tb/tb_xnor_compare_pipe.sv
// Directed bench for xnor_compare_pipe: three mask variants share stimulus.
// Counter expectations follow whether XNOR_MATCH_COUNT_EN is defined.
module tb_xnor_compare_pipe;
    import xnor_pkg::*;

`ifdef XNOR_MATCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] input1 = '0;
    logic [7:0] input2 = '0;
    logic       out_ready = 1'b1;
    logic       count_clear = 1'b0;

    logic       rdy0, rdy1, rdy2;
    logic       ov0, ov1, ov2;
    logic [7:0] res0, res1, res2;
    logic       eq0, eq1, eq2;
    logic [1:0] mc0, mc1, mc2;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    xnor_compare_pipe #(.WIDTH(8), .BubblesMask(16'h0000), .CNT_WIDTH(2)) dut0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy0),
        .input1(input1), .input2(input2), .out_valid(ov0), .out_ready(out_ready),
        .result(res0), .equal(eq0), .count_clear(count_clear), .match_count(mc0)
    );

    xnor_compare_pipe #(.WIDTH(8), .BubblesMask(16'h00FF), .CNT_WIDTH(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy1),
        .input1(input1), .input2(input2), .out_valid(ov1), .out_ready(out_ready),
        .result(res1), .equal(eq1), .count_clear(count_clear), .match_count(mc1)
    );

    xnor_compare_pipe #(.WIDTH(8), .BubblesMask(16'hFF00), .CNT_WIDTH(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy2),
        .input1(input1), .input2(input2), .out_valid(ov2), .out_ready(out_ready),
        .result(res2), .equal(eq2), .count_clear(count_clear), .match_count(mc2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
    endtask

    function automatic logic [1:0] occ0();
        return (dut0.s1_v && dut0.s2_v) ? OCC_FULL :
               (dut0.s1_v || dut0.s2_v) ? OCC_HALF : OCC_EMPTY;
    endfunction

    initial begin
        #2;
        chk("rst_out_valid", ov0, 0);
        chk("rst_result", res0, 0);
        chk("rst_equal", eq0, 0);
        chk("rst_match_count", mc0, 0);
        chk("rst_in_ready", rdy0, 1);
        #6 reset_n = 1'b1;
        step();

        drive(8'hA5, 8'hA5);
        step();
        in_valid = 1'b0;
        chk("lat_cycle1_valid", ov0, 0);
        step();
        chk("lat_cycle2_valid", ov0, 1);
        chk("same_result", res0, 8'hFF);
        chk("same_equal", eq0, 1);
        step();
        chk("drain_valid", ov0, 0);

        drive(8'h0F, 8'hF0);
        step();
        drive(8'h3C, 8'h3D);
        step();
        chk("compl_result", res0, 8'h00);
        chk("compl_equal", eq0, 0);
        drive(8'h00, 8'hFF);
        step();
        in_valid = 1'b0;
        chk("lsb_result", res0, 8'hFE);
        chk("lsb_equal", eq0, 0);
        step();
        chk("nomask_result", res0, 8'h00);
        chk("mask00ff_result", res1, 8'hFF);
        chk("mask00ff_equal", eq1, 1);
        chk("maskff00_result", res2, 8'hFF);
        chk("maskff00_equal", eq2, 1);
        step();

        out_ready = 1'b0;
        drive(8'h01, 8'h01);
        step();
        chk("bp_ready_after1", rdy0, 1);
        drive(8'h02, 8'h01);
        step();
        chk("bp_ready_after2", rdy0, 0);
        chk("bp_occ_full", occ0(), OCC_FULL);
        drive(8'h03, 8'h01);
        step();
        step();
        chk("bp_ready_held", rdy0, 0);
        chk("bp_result_held", res0, 8'hFF);
        chk("bp_valid_held", ov0, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", rdy0, 1);
        step();
        in_valid = 1'b0;
        chk("bp_word2", res0, 8'hFC);
        step();
        chk("bp_word3", res0, 8'hFD);
        chk("bp_word3_valid", ov0, 1);
        step();
        chk("bp_drained", ov0, 0);

        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        chk("cnt_cleared", mc0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(8'h55, 8'h55);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("cnt_saturated", mc0, CNT_ON ? 2'd3 : 2'd0);
        drive(8'h66, 8'h66);
        step();
        in_valid = 1'b0;
        step();
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        chk("cnt_clear_hit", mc0, CNT_ON ? 2'd1 : 2'd0);

        out_ready = 1'b0;
        drive(8'h11, 8'h11);
        step();
        drive(8'h22, 8'h22);
        step();
        in_valid = 1'b0;
        chk("pre_rst_occ", occ0(), OCC_FULL);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", ov0, 0);
        chk("mid_rst_result", res0, 0);
        chk("mid_rst_count", mc0, 0);
        #2 reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_ready", rdy0, 1);
        chk("post_rst_occ", occ0(), OCC_EMPTY);
        drive(8'h3C, 8'h3C);
        step();
        in_valid = 1'b0;
        chk("post_rst_lat1", ov0, 0);
        step();
        chk("post_rst_lat2", ov0, 1);
        chk("post_rst_result", res0, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
